matrix_operand_sequencer: RTL

Front/back-end stage wrapped around the 2x2 hypercube matrix multiplier. Accepts the eight 4-bit operand coefficients as a serial nibble stream with valid/ready handshake and presents them in parallel on A00..B11. Pulses STM, waits for EOM, and captures C00..C11. Returns the four 8-bit results as a byte stream with valid/ready/last handshake. A watchdog flags a multiplier that never reports EOM.

---
 rtl/matrix_pkg.sv | 37 +++
 rtl/matrix_operand_sequencer_if.sv | 39 +++
 rtl/eom_watchdog.sv | 34 +++
 rtl/matrix_operand_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the matrix operand sequencer
// Contents: sequencer state enum, operand/result counts and widths,
//           operand and result slot indices.
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam int NUM_OPERANDS = 8;
    localparam int NUM_RESULTS  = 4;
    localparam int COEF_W       = 4;
    localparam int PROD_W       = 8;

    localparam int NIB_IDX_W  = $clog2(NUM_OPERANDS);
    localparam int BYTE_IDX_W = $clog2(NUM_RESULTS);

    // Operand slots in arrival order on the nibble stream.
    localparam int IDX_A00 = 0;
    localparam int IDX_A01 = 1;
    localparam int IDX_A10 = 2;
    localparam int IDX_A11 = 3;
    localparam int IDX_B00 = 4;
    localparam int IDX_B01 = 5;
    localparam int IDX_B10 = 6;
    localparam int IDX_B11 = 7;

    // Result slots in departure order on the byte stream.
    localparam int IDX_C00 = 0;
    localparam int IDX_C01 = 1;
    localparam int IDX_C10 = 2;
    localparam int IDX_C11 = 3;

endpackage

// File: rtl/matrix_operand_sequencer_if.sv
// rtl/matrix_operand_sequencer_if.sv - bus bundle between sequencer, streams and multiplier
// Groups: nibble input stream (in_*), A/B operands + stm to the multiplier,
//         C products + eom from the multiplier, byte output stream (out_*),
//         busy/err status. master = sequencer side, slave = environment side.
interface matrix_operand_sequencer_if;
    import matrix_pkg::*;

    logic [COEF_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [COEF_W-1:0] a00, a01, a10, a11;
    logic [COEF_W-1:0] b00, b01, b10, b11;
    logic              stm;

    logic [PROD_W-1:0] c00, c01, c10, c11;
    logic              eom;

    logic [PROD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    logic              busy;
    logic              err;

    modport master (
        input  in_data, in_valid, c00, c01, c10, c11, eom, out_ready,
        output in_ready, a00, a01, a10, a11, b00, b01, b10, b11, stm,
               out_data, out_valid, out_last, busy, err
    );

    modport slave (
        output in_data, in_valid, c00, c01, c10, c11, eom, out_ready,
        input  in_ready, a00, a01, a10, a11, b00, b01, b10, b11, stm,
               out_data, out_valid, out_last, busy, err
    );

endinterface

// File: rtl/eom_watchdog.sv
// rtl/eom_watchdog.sv - cycle timer that flags a multiplier which never reports EOM
// Ports: i_clk, i_rst_n (async active-low), i_clear (zero the timer),
//        i_run (count this cycle), o_timeout (running and timer at TMO_CYCLES-1).
module eom_watchdog #(
    parameter int TMO_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_timeout
);

    localparam int              CNT_W    = $clog2(TMO_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] r_timer;
    logic             w_at_last;

    assign w_at_last = (r_timer == TMO_LAST);
    assign o_timeout = i_run & w_at_last;

    // Counting stops at the terminal value so the timer can never wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_run && !w_at_last) begin
            r_timer <= r_timer + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_operand_sequencer.sv
// rtl/matrix_operand_sequencer.sv - serial operand loader / result streamer around a 2x2 matrix multiplier
// Ports: i_clk, i_rst_n (async active-low), io_bus (master modport):
//        nibble stream in, A/B + stm out, C + eom in, byte stream out, busy/err.
module matrix_operand_sequencer
    import matrix_pkg::*;
#(
    parameter int TMO_CYCLES = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    matrix_operand_sequencer_if.master  io_bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [NIB_IDX_W-1:0]  r_nib_idx;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [COEF_W-1:0]     r_coef [NUM_OPERANDS];
    logic [PROD_W-1:0]     r_res  [NUM_RESULTS];
    logic                  r_err;
    logic                  r_in_ready;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_last_nib;
    logic w_last_byte;
    logic w_timeout;
    logic w_wd_clear;
    logic w_wd_run;
    logic w_stm;
    logic w_out_valid;
    logic w_out_last;

    assign w_last_nib  = (r_nib_idx == NIB_IDX_W'(NUM_OPERANDS - 1));
    assign w_last_byte = (r_byte_idx == BYTE_IDX_W'(NUM_RESULTS - 1));
    assign w_in_xfer   = io_bus.in_valid & r_in_ready;
    assign w_out_xfer  = w_out_valid & io_bus.out_ready;
    assign w_wd_clear  = (r_state == START);
    assign w_wd_run    = (r_state == WAIT);

    eom_watchdog #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_eom_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_wd_clear),
        .i_run     (w_wd_run),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next_state = r_state;
        w_stm        = 1'b0;
        w_out_valid  = 1'b0;
        w_out_last   = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_in_xfer && w_last_nib) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_stm        = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // EOM has priority over a timeout landing in the same cycle.
                if (io_bus.eom) begin
                    w_next_state = SEND;
                end else if (w_timeout) begin
                    w_next_state = LOAD;
                end
            end
            SEND: begin
                w_out_valid = 1'b1;
                w_out_last  = w_last_byte;
                if (io_bus.out_ready && w_last_byte) begin
                    w_next_state = LOAD;
                end
            end
            default: begin
                w_next_state = LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= LOAD;
            r_nib_idx  <= '0;
            r_byte_idx <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                r_coef[i] <= '0;
            end
            for (int i = 0; i < NUM_RESULTS; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            // Registered copy of "state is LOAD" so in_ready stays low while in reset.
            r_in_ready <= (w_next_state == LOAD);

            if (w_in_xfer) begin
                r_coef[r_nib_idx] <= io_bus.in_data;
                r_nib_idx         <= r_nib_idx + NIB_IDX_W'(1);
                if (r_nib_idx == '0) begin
                    r_err <= 1'b0;
                end
            end

            if (r_state == WAIT) begin
                if (io_bus.eom) begin
                    r_res[IDX_C00] <= io_bus.c00;
                    r_res[IDX_C01] <= io_bus.c01;
                    r_res[IDX_C10] <= io_bus.c10;
                    r_res[IDX_C11] <= io_bus.c11;
                    r_byte_idx     <= '0;
                end else if (w_timeout) begin
                    r_err     <= 1'b1;
                    r_nib_idx <= '0;
                end
            end

            if (w_out_xfer) begin
                r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
            end
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.stm       = w_stm;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_last  = w_out_last;
    assign io_bus.out_data  = w_out_valid ? r_res[r_byte_idx] : '0;
    assign io_bus.busy      = (r_state != LOAD) || (r_nib_idx != '0);
    assign io_bus.err       = r_err;

    assign io_bus.a00 = r_coef[IDX_A00];
    assign io_bus.a01 = r_coef[IDX_A01];
    assign io_bus.a10 = r_coef[IDX_A10];
    assign io_bus.a11 = r_coef[IDX_A11];
    assign io_bus.b00 = r_coef[IDX_B00];
    assign io_bus.b01 = r_coef[IDX_B01];
    assign io_bus.b10 = r_coef[IDX_B10];
    assign io_bus.b11 = r_coef[IDX_B11];

endmodule
